// File: rtl/tlu_dut_handshake.sv
// rtl/tlu_dut_handshake.sv - DUT side of the TLU trigger/busy/clock handshake
// Accepts a TLU trigger, clocks in its trigger number and offers it downstream.
module tlu_dut_handshake #(
  parameter int ID_BITS = 15,
  parameter int CLK_DIV = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               CLK40,
  input  logic               RESETB,
  input  logic               EN,
  input  logic               TLU_TRIGGER,
  output logic               TLU_BUSY,
  output logic               TLU_CLOCK,
  output logic [ID_BITS-1:0] TRIG_ID,
  output logic               TRIG_VALID,
  input  logic               TRIG_READY,
  input  logic               HOLD,
  output logic               TRIG_ERR,
  output logic [31:0]        TRIG_CNT
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (ID_BITS > 1) ? $clog2(ID_BITS) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ID_BITS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOW,
    S_SHIFT,
    S_OUTPUT,
    S_RELEASE
  } state_t;

  state_t             r_state;
  logic               r_trig_meta;
  logic               r_trig_s;
  logic               r_busy;
  logic               r_clk;
  logic               r_valid;
  logic               r_err;
  logic [DIV_W-1:0]   r_div;
  logic [BIT_W-1:0]   r_bit;
  logic [TMO_W-1:0]   r_tmo;
  logic [ID_BITS-2:0] r_shift;
  logic [ID_BITS-1:0] r_id;
  logic [31:0]        r_cnt;
  logic [ID_BITS-1:0] w_shift_next;

  // Upper ID_BITS-1 bits of the shift chain; the new bit always enters at the MSB.
  assign w_shift_next = {r_trig_s, r_shift};

  always_ff @(posedge CLK40 or negedge RESETB) begin
    if (!RESETB) begin
      r_state     <= S_IDLE;
      r_trig_meta <= 1'b0;
      r_trig_s    <= 1'b0;
      r_busy      <= 1'b0;
      r_clk       <= 1'b0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_div       <= '0;
      r_bit       <= '0;
      r_tmo       <= '0;
      r_shift     <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
    end else begin
      r_trig_meta <= TLU_TRIGGER;
      r_trig_s    <= r_trig_meta;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          r_clk  <= 1'b0;
          if (EN && r_trig_s) begin
            r_state <= S_WAIT_LOW;
            r_busy  <= 1'b1;
            r_tmo   <= '0;
          end
        end
        S_WAIT_LOW: begin
          if (!r_trig_s) begin
            r_state <= S_SHIFT;
            r_clk   <= 1'b1;
            r_div   <= '0;
            r_bit   <= '0;
          end else if (r_tmo == TMO_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_RELEASE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_SHIFT: begin
          if (r_div != DIV_LAST) begin
            r_div <= r_div + DIV_W'(1);
          end else begin
            r_div <= '0;
            if (r_clk) begin
              r_clk <= 1'b0;
            end else begin
              // Last cycle of the low phase: the TLU bit has settled through the synchronizer.
              r_shift <= w_shift_next[ID_BITS-1:1];
              if (r_bit == BIT_LAST) begin
                r_id    <= w_shift_next;
                r_valid <= 1'b1;
                r_state <= S_OUTPUT;
              end else begin
                r_bit <= r_bit + BIT_W'(1);
                r_clk <= 1'b1;
              end
            end
          end
        end
        S_OUTPUT: begin
          if (TRIG_READY) begin
            r_valid <= 1'b0;
            r_cnt   <= r_cnt + 32'd1;
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!HOLD && !r_trig_s) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_clk   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign TLU_BUSY   = r_busy;
  assign TLU_CLOCK  = r_clk;
  assign TRIG_ID    = r_id;
  assign TRIG_VALID = r_valid;
  assign TRIG_ERR   = r_err;
  assign TRIG_CNT   = r_cnt;

endmodule

// File: tb/tb_tlu_dut_handshake.sv
// tb/tb_tlu_dut_handshake.sv - self-checking bench for tlu_dut_handshake
// A behavioural TLU drives trigger numbers; expectations come from handshake rules.
module tb_tlu_dut_handshake;
  localparam int ID_BITS = 15;
  localparam int CLK_DIV = 4;
  localparam int TIMEOUT = 255;

  logic               CLK40 = 1'b0;
  logic               RESETB = 1'b0;
  logic               EN = 1'b0;
  logic               TLU_TRIGGER = 1'b0;
  logic               TRIG_READY = 1'b0;
  logic               HOLD = 1'b0;
  logic               TLU_BUSY;
  logic               TLU_CLOCK;
  logic               TRIG_VALID;
  logic               TRIG_ERR;
  logic [ID_BITS-1:0] TRIG_ID;
  logic [31:0]        TRIG_CNT;

  int                 n_cmp = 0;
  int                 n_err = 0;
  logic [31:0]        m_cnt = '0;
  logic [ID_BITS-1:0] m_id = '0;

  always #5 CLK40 = ~CLK40;

  tlu_dut_handshake #(
    .ID_BITS(ID_BITS),
    .CLK_DIV(CLK_DIV),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK40      (CLK40),
    .RESETB     (RESETB),
    .EN         (EN),
    .TLU_TRIGGER(TLU_TRIGGER),
    .TLU_BUSY   (TLU_BUSY),
    .TLU_CLOCK  (TLU_CLOCK),
    .TRIG_ID    (TRIG_ID),
    .TRIG_VALID (TRIG_VALID),
    .TRIG_READY (TRIG_READY),
    .HOLD       (HOLD),
    .TRIG_ERR   (TRIG_ERR),
    .TRIG_CNT   (TRIG_CNT)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One full TLU transaction; called and returns on a falling clock edge.
  task automatic handshake(input logic [ID_BITS-1:0] id, input int ready_lat,
                           input int hold_len, input bit en_drop);
    int   n, rises, run, bad_run, busy_lo, id_chg, guard, stall_bad, hold_bad;
    logic prev_clk;
    TRIG_READY  = (ready_lat == 0);
    HOLD        = 1'b0;
    TLU_TRIGGER = 1'b1;
    n = 0;
    do begin
      @(negedge CLK40);
      n++;
    end while (!TLU_BUSY && n < 10);
    check_eq("busy_rise_edge", n, 3);
    TLU_TRIGGER = 1'b0;
    if (en_drop) EN = 1'b0;

    rises = 0; run = 0; bad_run = 0; busy_lo = 0; id_chg = 0; guard = 0;
    prev_clk = 1'b0;
    while (guard < 2000) begin
      @(negedge CLK40);
      guard++;
      if (TRIG_VALID) break;
      if (TRIG_ID !== m_id) id_chg++;
      if (!TLU_BUSY) busy_lo++;
      if (TLU_CLOCK !== prev_clk) begin
        if (rises > 0 && run != CLK_DIV) bad_run++;
        run = 1;
        if (TLU_CLOCK) begin
          if (rises < ID_BITS) TLU_TRIGGER = id[rises];
          rises++;
        end
      end else begin
        run++;
      end
      prev_clk = TLU_CLOCK;
    end
    check_eq("valid_seen", TRIG_VALID, 1);
    check_eq("clock_periods", rises, ID_BITS);
    check_eq("phase_len_bad", bad_run, 0);
    check_eq("last_low_len", run, CLK_DIV);
    check_eq("busy_low_in_shift", busy_lo, 0);
    check_eq("id_changed_early", id_chg, 0);
    check_eq("trig_id", TRIG_ID, id);
    check_eq("clock_low_output", TLU_CLOCK, 0);

    TLU_TRIGGER = 1'b0;
    HOLD = (hold_len > 0);
    m_id = id;
    stall_bad = 0;
    for (int i = 0; i < ready_lat; i++) begin
      if (!TRIG_VALID || TRIG_ID !== id || !TLU_BUSY || TLU_CLOCK || TRIG_CNT !== m_cnt)
        stall_bad++;
      @(negedge CLK40);
    end
    if (ready_lat > 0) begin
      check_eq("stall_violations", stall_bad, 0);
      check_eq("valid_held", TRIG_VALID, 1);
      TRIG_READY = 1'b1;
    end
    @(negedge CLK40);
    m_cnt = m_cnt + 32'd1;
    check_eq("valid_drop", TRIG_VALID, 0);
    check_eq("trig_cnt", TRIG_CNT, m_cnt);

    if (hold_len > 0) begin
      hold_bad = 0;
      for (int i = 0; i < hold_len; i++) begin
        if (hold_len >= 12 && i == 3) TLU_TRIGGER = 1'b1;
        if (i == 8) TLU_TRIGGER = 1'b0;
        if (!TLU_BUSY || TLU_CLOCK || TRIG_VALID) hold_bad++;
        @(negedge CLK40);
      end
      check_eq("hold_violations", hold_bad, 0);
      HOLD = 1'b0;
      @(negedge CLK40);
      check_eq("busy_after_hold", TLU_BUSY, 0);
    end else begin
      n = 0;
      while (TLU_BUSY && n < 8) begin
        @(negedge CLK40);
        n++;
      end
      check_eq("busy_release", TLU_BUSY, 0);
    end
    check_eq("cnt_after_release", TRIG_CNT, m_cnt);
  endtask

  initial begin
    int n, err_cnt, err_at, bad;
    RESETB = 1'b0;
    EN = 1'b1;
    repeat (3) @(negedge CLK40);
    check_eq("rst_busy", TLU_BUSY, 0);
    check_eq("rst_clock", TLU_CLOCK, 0);
    check_eq("rst_valid", TRIG_VALID, 0);
    check_eq("rst_err", TRIG_ERR, 0);
    check_eq("rst_id", TRIG_ID, 0);
    check_eq("rst_cnt", TRIG_CNT, 0);
    RESETB = 1'b1;
    @(negedge CLK40);
    check_eq("idle_busy", TLU_BUSY, 0);

    handshake(15'h1234, 0, 0, 0);
    handshake(15'h7FFF, 100, 0, 0);
    handshake(15'h5A5A, 0, 50, 0);

    // Trigger never falls: the handshake must time out.
    TLU_TRIGGER = 1'b1;
    n = 0;
    do begin
      @(negedge CLK40);
      n++;
    end while (!TLU_BUSY && n < 10);
    check_eq("tmo_busy_rise", n, 3);
    err_cnt = 0; err_at = 0; bad = 0;
    for (int i = 1; i <= 397; i++) begin
      @(negedge CLK40);
      if (TRIG_ERR) begin
        err_cnt++;
        err_at = i;
      end
      if (TRIG_VALID || TLU_CLOCK || !TLU_BUSY) bad++;
    end
    check_eq("tmo_err_pulses", err_cnt, 1);
    check_eq("tmo_err_cycle", err_at, TIMEOUT);
    check_eq("tmo_violations", bad, 0);
    TLU_TRIGGER = 1'b0;
    n = 0;
    do begin
      @(negedge CLK40);
      n++;
    end while (TLU_BUSY && n < 10);
    check_eq("tmo_busy_fall", n, 3);
    check_eq("tmo_cnt", TRIG_CNT, m_cnt);

    // Disarmed: a trigger pulse must be ignored.
    EN = 1'b0;
    bad = 0;
    TLU_TRIGGER = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) TLU_TRIGGER = 1'b0;
      @(negedge CLK40);
      if (TLU_BUSY || TLU_CLOCK) bad++;
    end
    check_eq("en0_ignored", bad, 0);
    EN = 1'b1;

    handshake(15'h0001, 0, 0, 1);
    EN = 1'b1;

    for (int k = 0; k < 6; k++) begin
      handshake(ID_BITS'($urandom), ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20)),
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(12, 30)), 1'b0);
      repeat ($urandom_range(0, 5)) @(negedge CLK40);
    end

    // Reset while TLU_CLOCK is running.
    TRIG_READY = 1'b1;
    TLU_TRIGGER = 1'b1;
    n = 0;
    do begin
      @(negedge CLK40);
      n++;
    end while (!TLU_BUSY && n < 10);
    TLU_TRIGGER = 1'b0;
    n = 0;
    do begin
      @(negedge CLK40);
      n++;
    end while (!TLU_CLOCK && n < 40);
    check_eq("shift_clock_seen", TLU_CLOCK, 1);
    #2;
    RESETB = 1'b0;
    #1;
    check_eq("mid_rst_busy", TLU_BUSY, 0);
    check_eq("mid_rst_clock", TLU_CLOCK, 0);
    check_eq("mid_rst_valid", TRIG_VALID, 0);
    check_eq("mid_rst_id", TRIG_ID, 0);
    check_eq("mid_rst_cnt", TRIG_CNT, 0);
    m_cnt = '0;
    m_id = '0;
    TLU_TRIGGER = 1'b1;
    @(negedge CLK40);
    check_eq("mid_rst_hold_busy", TLU_BUSY, 0);
    @(negedge CLK40);
    RESETB = 1'b1;
    handshake(ID_BITS'($urandom), 3, 20, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
